// File: rtl/cpu_bus_frontend_pkg.sv
// ============================================================================
// Package : cpu_bus_frontend_pkg
// Shared bus-cycle state type, control bit positions and defaults for cpu_bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_bus_frontend_pkg;

  typedef enum logic [2:0] {
    BUS_IDLE = 3'd0,
    BUS_MEM  = 3'd1,
    BUS_RFSH = 3'd2,
    BUS_IO   = 3'd3,
    BUS_INTA = 3'd4
  } bus_state_t;

  localparam int CPU_BUS_SYNC_STAGES_DEFAULT = 2;
  localparam int CPU_BUS_FILTER_LEN_DEFAULT  = 3;

  // Bit positions of the control vector handed through the synchroniser.
  localparam int CTL_MREQ = 0;
  localparam int CTL_IORQ = 1;
  localparam int CTL_M1   = 2;
  localparam int CTL_RFSH = 3;
  localparam int CTL_RD   = 4;
  localparam int CTL_WR   = 5;

endpackage

`default_nettype wire

// File: rtl/cpu_bus_frontend_if.sv
// ============================================================================
// Interface : cpu_bus_frontend_if
// The shared cpu_bus: frontend drives it (master), decoders consume it (slave).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cpu_bus_frontend_if;
  import cpu_bus_frontend_pkg::*;

  logic [15:0] bus_a_raw;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_mreq;
  logic        bus_iorq;
  logic        bus_m1;
  logic        bus_rfsh;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_memreq;
  logic        bus_ioreq;
  logic        mem_start;
  logic        io_start;
  logic        bus_err;
  bus_state_t  bus_state;

  modport master (
    output bus_a_raw, bus_a, bus_d, bus_mreq, bus_iorq, bus_m1, bus_rfsh,
           bus_rd, bus_wr, bus_memreq, bus_ioreq, mem_start, io_start,
           bus_err, bus_state
  );

  modport slave (
    input bus_a_raw, bus_a, bus_d, bus_mreq, bus_iorq, bus_m1, bus_rfsh,
          bus_rd, bus_wr, bus_memreq, bus_ioreq, mem_start, io_start,
          bus_err, bus_state
  );

endinterface

`default_nettype wire

// File: rtl/cpu_bus_sync_filter.sv
// ============================================================================
// Module : cpu_bus_sync_filter
// Per-bit synchroniser; with CPU_BUS_GLITCH_FILTER_EN adds a level filter
// (GLITCH=1) or an equal-latency delay line (GLITCH=0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_bus_sync_filter #(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 3,
  parameter bit               GLITCH     = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] i_din,
  output wire       [WIDTH-1:0] o_dout
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_din};
    end
  end

`ifdef CPU_BUS_GLITCH_FILTER_EN
  if (GLITCH) begin : g_filter
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic       r_level;
      logic [2:0] r_cnt;
      logic       w_diff;

      assign w_diff = (r_sync[STAGES-1][b] != r_level);

      // Flip only on the FILTER_LEN-th consecutive differing sample.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_level <= RST_VAL[b];
          r_cnt   <= '0;
        end else if (!w_diff) begin
          r_cnt <= '0;
        end else if (r_cnt == 3'(FILTER_LEN - 1)) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end

      assign o_dout[b] = r_level;
    end
  end else begin : g_delay
    logic [FILTER_LEN-1:0][WIDTH-1:0] r_dly;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dly <= {FILTER_LEN{RST_VAL}};
      end else begin
        r_dly <= {r_dly[FILTER_LEN-2:0], r_sync[STAGES-1]};
      end
    end

    assign o_dout = r_dly[FILTER_LEN-1];
  end
`else
  assign o_dout = r_sync[STAGES-1];
`endif

endmodule

`default_nettype wire

// File: rtl/cpu_bus_frontend.sv
// ============================================================================
// Module : cpu_bus_frontend
// Synchronises raw Z80 pins onto cpu_bus and classifies each bus cycle.
// Optional macro CPU_BUS_GLITCH_FILTER_EN enables the control glitch filter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_bus_frontend
  import cpu_bus_frontend_pkg::*;
#(
  parameter int SYNC_STAGES = CPU_BUS_SYNC_STAGES_DEFAULT,
  parameter int FILTER_LEN  = CPU_BUS_FILTER_LEN_DEFAULT
) (
  input  wire logic          clk28,
  input  wire logic          rst,
  input  wire logic          n_mreq,
  input  wire logic          n_iorq,
  input  wire logic          n_m1,
  input  wire logic          n_rfsh,
  input  wire logic          n_rd,
  input  wire logic          n_wr,
  input  wire logic [15:0]   a_pin,
  input  wire logic [7:0]    d_pin,
  cpu_bus_frontend_if.master bus
);

  logic [5:0]  w_ctl_n;
  logic [5:0]  w_ctl;
  logic [23:0] w_ad;
  logic [15:0] w_a_raw;
  logic [7:0]  w_d;

  cpu_bus_sync_filter #(
    .WIDTH      (6),
    .STAGES     (SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .GLITCH     (1'b1),
    .RST_VAL    (6'h3F)
  ) u_ctl_sync (
    .clk    (clk28),
    .rst    (rst),
    .i_din  ({n_wr, n_rd, n_rfsh, n_m1, n_iorq, n_mreq}),
    .o_dout (w_ctl_n)
  );

  cpu_bus_sync_filter #(
    .WIDTH      (24),
    .STAGES     (SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .GLITCH     (1'b0),
    .RST_VAL    (24'h0)
  ) u_ad_sync (
    .clk    (clk28),
    .rst    (rst),
    .i_din  ({d_pin, a_pin}),
    .o_dout (w_ad)
  );

  assign w_ctl   = ~w_ctl_n;
  assign w_a_raw = w_ad[15:0];
  assign w_d     = w_ad[23:16];

  bus_state_t r_state;
  bus_state_t w_next;
  logic       r_memreq, r_ioreq, r_mem_start, r_io_start, r_err;
  logic       w_memreq, w_ioreq, w_mem_start, w_io_start, w_err;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_state     <= BUS_IDLE;
      r_memreq    <= 1'b0;
      r_ioreq     <= 1'b0;
      r_mem_start <= 1'b0;
      r_io_start  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_memreq    <= w_memreq;
      r_ioreq     <= w_ioreq;
      r_mem_start <= w_mem_start;
      r_io_start  <= w_io_start;
      r_err       <= w_err;
    end
  end

  // Active states only ever exit to IDLE, so a follow-on request costs one idle cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      BUS_IDLE: begin
        if (w_ctl[CTL_MREQ]) begin
          w_next = (w_ctl[CTL_RFSH] && !w_ctl[CTL_IORQ]) ? BUS_RFSH : BUS_MEM;
        end else if (w_ctl[CTL_IORQ]) begin
          w_next = w_ctl[CTL_M1] ? BUS_INTA : BUS_IO;
        end
      end
      BUS_MEM, BUS_RFSH: if (!w_ctl[CTL_MREQ]) w_next = BUS_IDLE;
      BUS_IO, BUS_INTA:  if (!w_ctl[CTL_IORQ]) w_next = BUS_IDLE;
      default:           w_next = BUS_IDLE;
    endcase
  end

  always_comb begin
    w_memreq    = (w_next == BUS_MEM);
    w_ioreq     = (w_next == BUS_IO);
    w_mem_start = (r_state == BUS_IDLE) && (w_next == BUS_MEM);
    w_io_start  = (r_state == BUS_IDLE) && (w_next == BUS_IO);
    w_err       = (r_state == BUS_IDLE) && w_ctl[CTL_MREQ] && w_ctl[CTL_IORQ];
  end

  logic [15:0] r_a_hold;
  logic [7:0]  r_d;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_a_hold <= '0;
      r_d      <= '0;
    end else begin
      if (r_state == BUS_IDLE) r_a_hold <= w_a_raw;
      if (w_ctl[CTL_WR] && (r_state == BUS_MEM || r_state == BUS_IO)) r_d <= w_d;
    end
  end

  assign bus.bus_a_raw  = w_a_raw;
  assign bus.bus_a      = (r_state == BUS_IDLE) ? w_a_raw : r_a_hold;
  assign bus.bus_d      = r_d;
  assign bus.bus_mreq   = w_ctl[CTL_MREQ];
  assign bus.bus_iorq   = w_ctl[CTL_IORQ];
  assign bus.bus_m1     = w_ctl[CTL_M1];
  assign bus.bus_rfsh   = w_ctl[CTL_RFSH];
  assign bus.bus_rd     = w_ctl[CTL_RD];
  assign bus.bus_wr     = w_ctl[CTL_WR];
  assign bus.bus_memreq = r_memreq;
  assign bus.bus_ioreq  = r_ioreq;
  assign bus.mem_start  = r_mem_start;
  assign bus.io_start   = r_io_start;
  assign bus.bus_err    = r_err;
  assign bus.bus_state  = r_state;

endmodule

`default_nettype wire
